dmem_ctrl: RTL and testbench

- Parametrised single-port data memory with a valid/ready request channel and a registered response channel.
- Successor to the fixed 16-bit, 8-word data memory, adding:
  - configurable width and depth
  - byte-lane write enables
  - backpressure
  - out-of-range error reporting
  - an optional post-reset clear sequencer
- Sits between the datapath load/store stage and the memory array.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_ctrl.sv | 132 +++++++++++++
 tb/tb_dmem_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared defaults, controller state encoding and byte-lane mask helper for dmem_ctrl.
package dmem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 8;

  // Widest word the mask helper supports; callers truncate to their own DATA_W.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [MAX_DATA_W-1:0] be_mask(input logic [MAX_BE_W-1:0] be);
    logic [MAX_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BE_W; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte-lane write enables and combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int AW     = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] lane_mask;

  assign lane_mask = DATA_W'(be_mask(MAX_BE_W'(be)));

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= (mem_q[addr] & ~lane_mask) | (wdata & lane_mask);
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request, one-cycle registered response, range check.
// Optional post-reset zero-fill of the array is built when DMEM_CLEAR_EN is defined.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  ADDR_W = DEF_ADDR_W,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              in_range, accept;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [BE_W-1:0]   mem_be;

`ifdef DMEM_CLEAR_EN
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              clr_last_q, clr_last_d;
`endif

  assign init_done = (state_q == ST_RUN);
  assign req_ready = init_done && (!rsp_valid_q || rsp_ready);
  assign in_range  = ({1'b0, req_addr} < DEPTH_L);
  assign accept    = req_valid && req_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .be    (mem_be),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    mem_we    = accept && req_we && in_range;
    mem_addr  = req_addr[AW-1:0];
    mem_wdata = req_wdata;
    mem_be    = req_be;
`ifdef DMEM_CLEAR_EN
    clr_cnt_d  = clr_cnt_q;
    clr_last_d = clr_last_q;
    // One word per cycle, then one extra cycle before RUN so init_done lands DEPTH+1 edges after release.
    if (state_q == ST_INIT) begin
      if (clr_last_q) begin
        state_d = ST_RUN;
      end else begin
        mem_we     = rst_n;
        mem_addr   = clr_cnt_q;
        mem_wdata  = '0;
        mem_be     = '1;
        clr_cnt_d  = clr_cnt_q + AW'(1);
        clr_last_d = (clr_cnt_q == AW'(DEPTH - 1));
      end
    end
`else
    if (state_q == ST_INIT) begin
      state_d = ST_RUN;
    end
`endif
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !in_range;
      rsp_rdata_d = (!req_we && in_range) ? mem_rdata : '0;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef DMEM_CLEAR_EN
      clr_cnt_q   <= '0;
      clr_last_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef DMEM_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
      clr_last_q  <= clr_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed cases plus random traffic against a word-array reference model.
// Define DMEM_CLEAR_EN for both bench and RTL to exercise the zero-fill sequence.
module tb_dmem_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 8;
  localparam int BE_W   = DATA_W / 8;
`ifdef DMEM_CLEAR_EN
  localparam int INIT_EDGES = DEPTH + 1;
`else
  localparam int INIT_EDGES = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  dmem_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Reference model: the memory as a plain array plus the expected response slot.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                exp_valid;
  bit                exp_err;
  bit                exp_init;
  logic [DATA_W-1:0] exp_rdata;
  int                edges_since_release;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_valid           = 1'b0;
    exp_err             = 1'b0;
    exp_rdata           = '0;
    exp_init            = 1'b0;
    edges_since_release = 0;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
  endtask

  // Called at a falling edge: drive one cycle of inputs, predict the next rising edge, check after it.
  task automatic step(input bit v, input bit we, input int addr,
                      input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be, input bit rr);
    bit exp_rdy;
    req_valid = v;
    req_we    = we;
    req_addr  = ADDR_W'(addr);
    req_wdata = wd;
    req_be    = be;
    rsp_ready = rr;
    #1;
    exp_rdy = exp_init && (!exp_valid || rr);
    check("req_ready", req_ready, exp_rdy);
    if (v && exp_rdy) begin
      exp_valid = 1'b1;
      if (addr < DEPTH) begin
        exp_err = 1'b0;
        if (we) begin
          for (int i = 0; i < BE_W; i++)
            if (be[i]) ref_mem[addr][8*i +: 8] = wd[8*i +: 8];
          exp_rdata = '0;
        end else begin
          exp_rdata = ref_mem[addr];
        end
      end else begin
        exp_err   = 1'b1;
        exp_rdata = '0;
      end
    end else if (rr) begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = '0;
    end
    edges_since_release++;
    if (!exp_init && edges_since_release >= INIT_EDGES) begin
      exp_init = 1'b1;
`ifdef DMEM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    end
    @(posedge clk);
    @(negedge clk);
    check("init_done", init_done, exp_init);
    check("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) begin
      check("rsp_err", rsp_err, exp_err);
      check("rsp_rdata", rsp_rdata, exp_rdata);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, '0, 1'b1);
  endtask

  // Assert reset asynchronously at a falling edge, hold it over some rising edges, release at a falling edge.
  task automatic do_reset(input int hold_edges);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);
    repeat (hold_edges) @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] keep3;
    int                a;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset(2);
    idle_steps(INIT_EDGES);
    check("init_after_release", init_done, 1);

`ifdef DMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, i, '0, '0, 1'b1);
      check("clear_zero", rsp_rdata, 0);
    end
    @(negedge clk);
    do_reset(1);
    idle_steps(4);
    do_reset(1);
    idle_steps(INIT_EDGES - 1);
    check("clear_restart_pending", init_done, 0);
    idle_steps(1);
    check("clear_restart_done", init_done, 1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, i, '0, '0, 1'b1);
`endif

    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, i, DATA_W'($urandom), '1, 1'b1);

    step(1'b1, 1'b1, 3, 16'hABCD, 2'b11, 1'b1);
    check("wr3_rdata", rsp_rdata, 0);
    step(1'b1, 1'b0, 3, '0, '0, 1'b1);
    check("rd3_abcd", rsp_rdata, 16'hABCD);
    step(1'b1, 1'b1, 5, 16'h1234, 2'b11, 1'b1);
    step(1'b1, 1'b1, 5, 16'hFF00, 2'b10, 1'b1);
    step(1'b1, 1'b0, 5, '0, '0, 1'b1);
    check("rd5_merge", rsp_rdata, 16'hFF34);
    step(1'b1, 1'b1, 6, 16'h7777, 2'b00, 1'b1);
    check("be0_rsp", rsp_valid, 1);

    step(1'b1, 1'b0, DEPTH, '0, '0, 1'b1);
    check("rd_oor_err", rsp_err, 1);
    check("rd_oor_data", rsp_rdata, 0);
    step(1'b1, 1'b1, DEPTH + 1, 16'h5555, 2'b11, 1'b1);
    check("wr_oor_err", rsp_err, 1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, i, '0, '0, 1'b1);

    step(1'b1, 1'b0, 1, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2, '0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, i, '0, '0, 1'b1);
    idle_steps(1);

    for (int i = 0; i < 500; i++) begin
      a = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, DEPTH + 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, DATA_W'($urandom),
           BE_W'($urandom), $urandom_range(0, 9) < 7);
    end
    idle_steps(2);

    step(1'b1, 1'b1, 3, 16'hC0DE, 2'b11, 1'b1);
    step(1'b1, 1'b0, 3, '0, '0, 1'b0);
    keep3 = ref_mem[3];
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = ADDR_W'(3);
    req_wdata = 16'h0F0F;
    req_be    = 2'b11;
    do_reset(2);
    idle_steps(INIT_EDGES);
    step(1'b1, 1'b0, 3, '0, '0, 1'b1);
`ifndef DMEM_CLEAR_EN
    check("rd3_after_reset", rsp_rdata, 32'(keep3));
`else
    check("rd3_after_clear", rsp_rdata, 0);
`endif
    idle_steps(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
